main: RTL and testbench

- Single-cycle RV32I integer datapath.
- The instruction word is supplied externally on dataIN each cycle, so the block contains no instruction memory.
- Contains PC register, 32x32 register file, immediate generator, ALU, control decoder and a 256-word internal data memory.
- Debug outputs expose architectural activity for verification.

---
 rtl/main.sv | 254 +++++++++++++++++++++++++
 tb/tb_main.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/main.sv
`default_nettype none
// ============================================================================
//  Module   : main
//  Brief    : Single-cycle RV32I integer datapath. The instruction arrives on
//             dataIN every cycle; PC, 32x32 register file, immediate
//             generator, ALU, control decode and a word-addressed data
//             memory live here.
//  Revision : 1.0 - initial release
// ============================================================================
module main #(
    parameter int          DMEM_WORDS = 256,
    parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] dataIN,
    input  logic        en,
    input  logic        RW,
    output logic [31:0] pc_out,
    output logic [31:0] alu_out,
    output logic        wb_en,
    output logic [4:0]  wb_addr,
    output logic [31:0] wb_data
);

    localparam int         c_AW        = $clog2(DMEM_WORDS);
    localparam logic [6:0] c_OP_R      = 7'b0110011;
    localparam logic [6:0] c_OP_I      = 7'b0010011;
    localparam logic [6:0] c_OP_LOAD   = 7'b0000011;
    localparam logic [6:0] c_OP_STORE  = 7'b0100011;
    localparam logic [6:0] c_OP_LUI    = 7'b0110111;
    localparam logic [6:0] c_OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] c_OP_BRANCH = 7'b1100011;
    localparam logic [6:0] c_OP_JAL    = 7'b1101111;
    localparam logic [6:0] c_OP_JALR   = 7'b1100111;

    // Architectural state
    logic [31:0] r_pc;
    logic [31:0] r_regs [32];
    logic [31:0] r_mem  [DMEM_WORDS];

    // Instruction fields
    logic [6:0]  w_opcode;
    logic [4:0]  w_rd;
    logic [4:0]  w_rs1;
    logic [4:0]  w_rs2;
    logic [2:0]  w_funct3;
    logic        w_funct7b5;

    assign w_opcode   = dataIN[6:0];
    assign w_rd       = dataIN[11:7];
    assign w_funct3   = dataIN[14:12];
    assign w_rs1      = dataIN[19:15];
    assign w_rs2      = dataIN[24:20];
    assign w_funct7b5 = dataIN[30];

    // Immediates, sign-extended from bit 31 of the instruction
    logic [31:0] w_imm_i;
    logic [31:0] w_imm_s;
    logic [31:0] w_imm_b;
    logic [31:0] w_imm_u;
    logic [31:0] w_imm_j;

    assign w_imm_i = {{20{dataIN[31]}}, dataIN[31:20]};
    assign w_imm_s = {{20{dataIN[31]}}, dataIN[31:25], dataIN[11:7]};
    assign w_imm_b = {{19{dataIN[31]}}, dataIN[31], dataIN[7], dataIN[30:25], dataIN[11:8], 1'b0};
    assign w_imm_u = {dataIN[31:12], 12'h000};
    assign w_imm_j = {{11{dataIN[31]}}, dataIN[31], dataIN[19:12], dataIN[20], dataIN[30:21], 1'b0};

    // Register reads are combinational; x0 is hard-wired to zero
    logic [31:0] w_rs1_val;
    logic [31:0] w_rs2_val;

    assign w_rs1_val = (w_rs1 == 5'd0) ? 32'd0 : r_regs[w_rs1];
    assign w_rs2_val = (w_rs2 == 5'd0) ? 32'd0 : r_regs[w_rs2];

    // Opcode class decode
    logic w_is_r, w_is_i, w_is_load, w_is_store, w_is_lui, w_is_auipc;
    logic w_is_branch, w_is_jal, w_is_jalr;

    assign w_is_r      = (w_opcode == c_OP_R);
    assign w_is_i      = (w_opcode == c_OP_I);
    assign w_is_load   = (w_opcode == c_OP_LOAD);
    assign w_is_store  = (w_opcode == c_OP_STORE);
    assign w_is_lui    = (w_opcode == c_OP_LUI);
    assign w_is_auipc  = (w_opcode == c_OP_AUIPC);
    assign w_is_branch = (w_opcode == c_OP_BRANCH);
    assign w_is_jal    = (w_opcode == c_OP_JAL);
    assign w_is_jalr   = (w_opcode == c_OP_JALR);

    // ALU operand and function selection; non-ALU opcodes default to an add
    logic [31:0] w_alu_a;
    logic [31:0] w_alu_b;
    logic [2:0]  w_alu_f3;
    logic        w_alu_alt;

    // Pick ALU operands and operation from the opcode class
    always_comb begin
        w_alu_a   = w_rs1_val;
        w_alu_b   = w_imm_i;
        w_alu_f3  = 3'b000;
        w_alu_alt = 1'b0;
        case (w_opcode)
            c_OP_R: begin
                w_alu_b   = w_rs2_val;
                w_alu_f3  = w_funct3;
                w_alu_alt = w_funct7b5;
            end
            c_OP_I: begin
                w_alu_f3  = w_funct3;
                // bit 30 only selects SRAI; for ADDI it is immediate data
                w_alu_alt = (w_funct3 == 3'b101) && w_funct7b5;
            end
            c_OP_STORE: begin
                w_alu_b = w_imm_s;
            end
            c_OP_LUI: begin
                w_alu_a = 32'd0;
                w_alu_b = w_imm_u;
            end
            c_OP_AUIPC: begin
                w_alu_a = r_pc;
                w_alu_b = w_imm_u;
            end
            c_OP_JAL: begin
                w_alu_a = r_pc;
                w_alu_b = w_imm_j;
            end
            c_OP_BRANCH: begin
                w_alu_b   = w_rs2_val;
                w_alu_alt = 1'b1;
            end
            default: ;
        endcase
    end

    logic [31:0] w_alu;
    logic [4:0]  w_shamt;
    logic [31:0] w_sra;

    assign w_shamt = w_alu_b[4:0];
    assign w_sra   = $unsigned($signed(w_alu_a) >>> w_shamt);

    // ALU: alt selects SUB for funct3=000 and SRA for funct3=101
    always_comb begin
        w_alu = 32'd0;
        case (w_alu_f3)
            3'b000:  w_alu = w_alu_alt ? (w_alu_a - w_alu_b) : (w_alu_a + w_alu_b);
            3'b001:  w_alu = w_alu_a << w_shamt;
            3'b010:  w_alu = {31'd0, $signed(w_alu_a) < $signed(w_alu_b)};
            3'b011:  w_alu = {31'd0, w_alu_a < w_alu_b};
            3'b100:  w_alu = w_alu_a ^ w_alu_b;
            3'b101:  w_alu = w_alu_alt ? w_sra : (w_alu_a >> w_shamt);
            3'b110:  w_alu = w_alu_a | w_alu_b;
            default: w_alu = w_alu_a & w_alu_b;
        endcase
    end

    logic w_taken;

    // Branch condition evaluation on rs1/rs2
    always_comb begin
        w_taken = 1'b0;
        case (w_funct3)
            3'b000:  w_taken = (w_rs1_val == w_rs2_val);
            3'b001:  w_taken = (w_rs1_val != w_rs2_val);
            3'b100:  w_taken = ($signed(w_rs1_val) <  $signed(w_rs2_val));
            3'b101:  w_taken = ($signed(w_rs1_val) >= $signed(w_rs2_val));
            3'b110:  w_taken = (w_rs1_val <  w_rs2_val);
            3'b111:  w_taken = (w_rs1_val >= w_rs2_val);
            default: w_taken = 1'b0;
        endcase
    end

    logic [31:0] w_pc_plus4;
    logic [31:0] w_jalr_sum;
    logic [31:0] w_next_pc;

    assign w_pc_plus4 = r_pc + 32'd4;
    assign w_jalr_sum = w_rs1_val + w_imm_i;

    // Next-PC selection: sequential, taken branch, JAL or JALR
    always_comb begin
        w_next_pc = w_pc_plus4;
        if (w_is_jal) begin
            w_next_pc = r_pc + w_imm_j;
        end else if (w_is_jalr) begin
            w_next_pc = {w_jalr_sum[31:1], 1'b0};
        end else if (w_is_branch && w_taken) begin
            w_next_pc = r_pc + w_imm_b;
        end
    end

    // Data memory: address wraps on the word-index bits, byte offset ignored
    logic [c_AW-1:0] w_mem_idx;
    logic [31:0]     w_load_data;
    logic            w_store_we;

    assign w_mem_idx   = w_alu[c_AW+1:2];
    assign w_load_data = r_mem[w_mem_idx];
    assign w_store_we  = !rst && en && RW && w_is_store;

    // Write-back source and strobe
    logic w_writes_rd;

    assign w_writes_rd = w_is_r || w_is_i || w_is_load || w_is_lui
                      || w_is_auipc || w_is_jal || w_is_jalr;

    // Select the write-back value for the destination register
    always_comb begin
        wb_data = w_alu;
        if (w_is_load) begin
            wb_data = w_load_data;
        end else if (w_is_jal || w_is_jalr) begin
            wb_data = w_pc_plus4;
        end else if (w_is_lui) begin
            wb_data = w_imm_u;
        end
    end

    assign wb_en   = en && w_writes_rd;
    assign wb_addr = w_rd;
    assign alu_out = w_alu;
    assign pc_out  = r_pc;

    // PC register: reset wins over enable
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc <= RESET_PC;
        end else if (en) begin
            r_pc <= w_next_pc;
        end
    end

    // Register file: cleared on reset, x0 never written
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                r_regs[i] <= 32'd0;
            end
        end else if (wb_en && (w_rd != 5'd0)) begin
            r_regs[w_rd] <= wb_data;
        end
    end

    // Data memory store port; contents survive reset
    always_ff @(posedge clk) begin
        if (w_store_we) begin
            r_mem[w_mem_idx] <= w_rs2_val;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_main.sv
`default_nettype none
// ============================================================================
//  Module   : tb_main
//  Brief    : Self-checking bench for main: directed program with literal
//             expectations plus randomized instructions compared every cycle
//             against an instruction-level reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_main;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        en = 1'b0;
    logic        RW = 1'b0;
    logic [31:0] dataIN = 32'd0;
    logic [31:0] pc_out;
    logic [31:0] alu_out;
    logic        wb_en;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;

    always #5 clk = ~clk;

    main #(.DMEM_WORDS(256), .RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .rst(rst), .dataIN(dataIN), .en(en), .RW(RW),
        .pc_out(pc_out), .alu_out(alu_out), .wb_en(wb_en),
        .wb_addr(wb_addr), .wb_data(wb_data)
    );

    int checks = 0;
    int failures = 0;
    bit run_cmp = 1'b0;

    // Reference model state
    logic [31:0] m_pc = 32'd0;
    logic [31:0] m_regs [32];
    logic [31:0] m_mem  [256];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] alu_op(input logic [2:0] f3, input logic [31:0] x,
                                           input logic [31:0] y, input logic alt);
        logic signed [31:0] sx;
        int sh;
        sx = x;
        sh = int'(y % 32);
        case (f3)
            3'd0: return alt ? x - y : x + y;
            3'd1: return x << sh;
            3'd2: return ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
            3'd3: return (x < y) ? 32'd1 : 32'd0;
            3'd4: return x ^ y;
            3'd5: return alt ? 32'(sx >>> sh) : x >> sh;
            3'd6: return x | y;
            default: return x & y;
        endcase
    endfunction

    // Instruction-level semantics evaluated from the model's current state
    function automatic void model_eval(input logic [31:0] ins, input logic e, input logic w,
                                       output logic achk, output logic [31:0] alu,
                                       output logic wbe, output logic [31:0] wbd,
                                       output logic [31:0] npc, output logic st,
                                       output logic [7:0] sidx, output logic [31:0] sdata);
        logic [31:0] a, b, ii, is, ib, iu, ij, sgn;
        logic [2:0] f3;
        logic writes, tk;
        a   = m_regs[ins[19:15]];
        b   = m_regs[ins[24:20]];
        f3  = ins[14:12];
        sgn = ins[31] ? 32'hFFFF_FFFF : 32'd0;
        ii  = 32'($signed(ins) >>> 20);
        is  = (sgn << 12) + 32'(ins[31:25]) * 32 + 32'(ins[11:7]);
        ib  = (sgn << 12) + 32'(ins[7]) * 2048 + 32'(ins[30:25]) * 32 + 32'(ins[11:8]) * 2;
        iu  = ins & 32'hFFFF_F000;
        ij  = (sgn << 20) + 32'(ins[19:12]) * 4096 + 32'(ins[20]) * 2048 + 32'(ins[30:21]) * 2;
        achk = 1'b0; alu = 32'd0; wbd = 32'd0; npc = m_pc + 4;
        st = 1'b0; sidx = 8'd0; sdata = b; writes = 1'b0; tk = 1'b0;
        case (ins[6:0])
            7'h33: begin alu = alu_op(f3, a, b, ins[30]); achk = 1; writes = 1; wbd = alu; end
            7'h13: begin alu = alu_op(f3, a, ii, (f3 == 3'd5) && ins[30]); achk = 1; writes = 1; wbd = alu; end
            7'h03: begin alu = a + ii; achk = 1; writes = 1; wbd = m_mem[alu[9:2]]; end
            7'h23: begin alu = a + is; achk = 1; st = e && w; sidx = alu[9:2]; end
            7'h37: begin alu = iu; achk = 1; writes = 1; wbd = iu; end
            7'h17: begin alu = m_pc + iu; achk = 1; writes = 1; wbd = alu; end
            7'h63: begin
                case (f3)
                    3'd0: tk = (a == b);
                    3'd1: tk = (a != b);
                    3'd4: tk = ($signed(a) < $signed(b));
                    3'd5: tk = ($signed(a) >= $signed(b));
                    3'd6: tk = (a < b);
                    3'd7: tk = (a >= b);
                    default: tk = 1'b0;
                endcase
                if (tk) npc = m_pc + ib;
            end
            7'h6F: begin writes = 1; wbd = m_pc + 4; npc = m_pc + ij; end
            7'h67: begin alu = a + ii; achk = 1; writes = 1; wbd = m_pc + 4; npc = alu & ~32'd1; end
            default: ;
        endcase
        wbe = e && writes;
    endfunction

    // Per-cycle comparison of every meaningful output against the model
    logic        c_achk, c_wbe, c_st;
    logic [31:0] c_alu, c_wbd, c_npc, c_sdata;
    logic [7:0]  c_sidx;
    always @(negedge clk) begin
        if (run_cmp) begin
            model_eval(dataIN, en, RW, c_achk, c_alu, c_wbe, c_wbd, c_npc, c_st, c_sidx, c_sdata);
            check("pc_out", pc_out, m_pc);
            if (c_achk) check("alu_out", alu_out, c_alu);
            check("wb_en", {31'd0, wb_en}, {31'd0, c_wbe});
            if (c_wbe) begin
                check("wb_addr", {27'd0, wb_addr}, {27'd0, dataIN[11:7]});
                check("wb_data", wb_data, c_wbd);
            end
        end
    end

    task automatic drive(input logic [31:0] ins, input logic e, input logic w, input logic r);
        dataIN = ins; en = e; RW = w; rst = r;
        #2;
    endtask

    // Advance one clock and retire the current instruction in the model
    task automatic tick();
        logic achk, wbe, st;
        logic [31:0] alu, wbd, npc, sdata;
        logic [7:0] sidx;
        @(posedge clk);
        if (rst) begin
            m_pc = 32'd0;
            for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
        end else if (en) begin
            model_eval(dataIN, en, RW, achk, alu, wbe, wbd, npc, st, sidx, sdata);
            if (wbe && dataIN[11:7] != 5'd0) m_regs[dataIN[11:7]] = wbd;
            if (st) m_mem[sidx] = sdata;
            m_pc = npc;
        end
        #1;
    endtask

    function automatic logic [31:0] rand_instr();
        logic [4:0] rd, rs1, rs2;
        logic [2:0] f3;
        logic [11:0] imm;
        logic [31:0] r;
        int sel;
        rd  = 5'($urandom_range(0, 9));
        rs1 = 5'($urandom_range(0, 7));
        rs2 = 5'($urandom_range(0, 7));
        f3  = 3'($urandom);
        imm = 12'($urandom);
        r   = $urandom;
        sel = $urandom_range(0, 9);
        case (sel)
            0, 1: return {((f3 == 3'd0 || f3 == 3'd5) && r[0]) ? 7'h20 : 7'h00, rs2, rs1, f3, rd, 7'h33};
            2, 3: begin
                if (f3 == 3'd1) imm = {7'h00, imm[4:0]};
                if (f3 == 3'd5) imm = {r[1] ? 7'h20 : 7'h00, imm[4:0]};
                return {imm, rs1, f3, rd, 7'h13};
            end
            4: return {imm, rs1, 3'b010, rd, 7'h03};
            5: return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'h23};
            6: return {r[31:12], rd, r[0] ? 7'h37 : 7'h17};
            7: begin
                f3 = (f3 == 3'd2 || f3 == 3'd3) ? 3'd0 : f3;
                return {r[31:25], rs2, rs1, f3, r[11:7], 7'h63};
            end
            8: return r[0] ? {r[31:12], rd, 7'h6F} : {imm, rs1, 3'b000, rd, 7'h67};
            default: return {r[31:7], r[1] ? 7'h0F : 7'h73};
        endcase
    endfunction

    initial begin
        for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
        for (int i = 0; i < 256; i++) m_mem[i] = 32'd0;

        drive(32'h0000_0013, 1'b1, 1'b0, 1'b1);
        tick();
        run_cmp = 1'b1;
        check("reset_pc", pc_out, 32'd0);

        // Give every memory word a known value: SW x0, 4k(x0)
        for (int k = 0; k < 256; k++) begin
            logic [11:0] im;
            im = 12'(k * 4);
            drive({im[11:5], 5'd0, 5'd0, 3'b010, im[4:0], 7'h23}, 1'b1, 1'b1, 1'b0);
            tick();
        end

        // Reset again; memory must keep its contents
        drive(32'h0000_0013, 1'b1, 1'b0, 1'b1);
        tick();
        check("reset_pc2", pc_out, 32'd0);

        drive(32'h0040_0093, 1'b1, 1'b0, 1'b0);          // ADDI x1,x0,4
        check("addi_wben", {31'd0, wb_en}, 32'd1);
        check("addi_rd", {27'd0, wb_addr}, 32'd1);
        check("addi_data", wb_data, 32'd4);
        tick();
        check("pc_after_addi", pc_out, 32'd4);
        drive(32'h0050_0113, 1'b1, 1'b0, 1'b0);          // ADDI x2,x0,5
        check("addi2_rd", {27'd0, wb_addr}, 32'd2);
        check("addi2_data", wb_data, 32'd5);
        tick();
        drive(32'h4011_0233, 1'b1, 1'b1, 1'b0);          // SUB x4,x2,x1
        check("sub_alu", alu_out, 32'd1);
        tick();
        for (int k = 0; k < 3; k++) begin                 // en=0 hold
            drive(32'h0070_0093, 1'b0, 1'b1, 1'b0);
            check("hold_wben", {31'd0, wb_en}, 32'd0);
            tick();
        end
        check("hold_pc", pc_out, 32'd12);
        drive(32'h0000_83B3, 1'b1, 1'b0, 1'b0);          // ADD x7,x1,x0
        check("x1_kept", alu_out, 32'd4);
        tick();
        drive(32'h0010_8463, 1'b1, 1'b0, 1'b0);          // BEQ x1,x1,+8 @16
        tick();
        check("beq_pc", pc_out, 32'd24);
        drive(32'h0010_9463, 1'b1, 1'b0, 1'b0);          // BNE x1,x1,+8 @24
        tick();
        check("bne_pc", pc_out, 32'd28);
        drive(32'h00C0_00EF, 1'b1, 1'b0, 1'b0);          // JAL x1,+12 @28
        check("jal_link", wb_data, 32'd32);
        tick();
        check("jal_pc", pc_out, 32'd40);
        drive(32'h0020_2023, 1'b1, 1'b0, 1'b0);          // SW x2,0(x0), RW=0
        tick();
        drive(32'h0000_2283, 1'b1, 1'b0, 1'b0);          // LW x5,0(x0)
        check("lw_blocked", wb_data, 32'd0);
        tick();
        drive(32'h0020_2023, 1'b1, 1'b1, 1'b0);          // SW x2,0(x0), RW=1
        tick();
        drive(32'h0000_2283, 1'b1, 1'b0, 1'b0);          // LW x5,0(x0)
        check("lw_stored", wb_data, 32'd5);
        tick();
        drive(32'h0090_0013, 1'b1, 1'b0, 1'b0);          // ADDI x0,x0,9
        tick();
        drive(32'h0000_03B3, 1'b1, 1'b0, 1'b0);          // ADD x7,x0,x0
        check("x0_zero", alu_out, 32'd0);
        tick();
        drive(32'h0040_0093, 1'b1, 1'b0, 1'b0);          // ADDI x1,x0,4
        tick();
        drive(32'h4020_8333, 1'b1, 1'b0, 1'b0);          // SUB x6,x1,x2
        check("sub_neg", alu_out, 32'hFFFF_FFFF);
        tick();
        drive(32'h8000_01B7, 1'b1, 1'b0, 1'b0);          // LUI x3,0x80000
        check("lui_data", wb_data, 32'h8000_0000);
        tick();
        drive(32'h4041_D413, 1'b1, 1'b0, 1'b0);          // SRAI x8,x3,4
        check("srai", alu_out, 32'hF800_0000);
        tick();
        drive(32'h0070_0093, 1'b1, 1'b0, 1'b1);          // reset mid-program
        tick();
        check("midrst_pc", pc_out, 32'd0);
        drive(32'h0003_03B3, 1'b1, 1'b0, 1'b0);          // ADD x7,x6,x0
        check("midrst_x6", alu_out, 32'd0);
        tick();

        // Randomized instruction stream
        for (int n = 0; n < 3000; n++) begin
            drive(rand_instr(), ($urandom_range(0, 7) != 0), 1'($urandom),
                  ($urandom_range(0, 63) == 0));
            tick();
        end

        run_cmp = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
